// File: rtl/pc_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : pc_gen_if                                                    |
// | Brief    : Control/fetch bundle between CTRL/ID and the PC generator.   |
// |            master = controller side, slave = pc_gen side.               |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
interface pc_gen_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_target_address_i;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               pc_misalign_o;
  logic               redirect_pending_o;
  logic [31:0]        fetch_count_o;

  modport master (
    output stall, flush, new_pc, branch_flag_i, branch_target_address_i,
    input  pc, ce, pc_misalign_o, redirect_pending_o, fetch_count_o
  );

  modport slave (
    input  stall, flush, new_pc, branch_flag_i, branch_target_address_i,
    output pc, ce, pc_misalign_o, redirect_pending_o, fetch_count_o
  );
endinterface
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : pc_gen                                                       |
// | Brief    : Fetch-stage program counter with wake-up delay, buffered     |
// |            branch redirect under stall, misalignment flag and a         |
// |            retired-advance counter.                                     |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
module pc_gen #(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       STEP         = 4,
  parameter int unsigned       STALL_W      = 6,
  parameter int unsigned       ENABLE_DELAY = 1
) (
  input  logic    clk,
  input  logic    rst,
  pc_gen_if.slave bus
);

  localparam int unsigned LSB_W = $clog2(STEP);
  localparam int unsigned CNT_W = (ENABLE_DELAY > 1) ? $clog2(ENABLE_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENABLE_DELAY - 1);
  localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);

  typedef enum logic [0:0] {
    S_WAKE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q, ce_d;
  logic              misalign_q, misalign_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [31:0]       count_q, count_d;

  // Misalignment is derived from the next pc so it lands on the same edge.
  generate
    if (STEP == 1) begin : g_aligned
      assign misalign_d = 1'b0;
    end else begin : g_lowbits
      assign misalign_d = |pc_d[LSB_W-1:0];
    end

    // Only stall[0] freezes the PC; the upper bits are part of the shared
    // pipeline stall vector and deliberately ignored here.
    if (STALL_W > 1) begin : g_stall_hi
      logic unused_stall_hi;
      assign unused_stall_hi = ^bus.stall[STALL_W-1:1];
    end
  endgenerate

  // Next-state: reset, wake-up countdown, then the RUN redirect priority chain.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    ce_d       = ce_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    count_d    = count_q;
    if (!rst) begin
      state_d    = S_WAKE;
      cnt_d      = '0;
      pc_d       = RESET_VECTOR;
      ce_d       = 1'b0;
      pend_d     = 1'b0;
      pend_tgt_d = '0;
      count_d    = '0;
    end else if (state_q == S_WAKE) begin
      // pc stays at the reset vector; flush and branch have no effect yet.
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        state_d = S_RUN;
        ce_d    = 1'b1;
      end
    end else begin
      if (bus.flush) begin
        pc_d    = bus.new_pc;
        pend_d  = 1'b0;
        count_d = count_q + 32'd1;
      end else if (bus.stall[0]) begin
        // Hold fetch; remember only the most recent branch target.
        if (bus.branch_flag_i) begin
          pend_d     = 1'b1;
          pend_tgt_d = bus.branch_target_address_i;
        end
      end else if (bus.branch_flag_i) begin
        pc_d    = bus.branch_target_address_i;
        pend_d  = 1'b0;
        count_d = count_q + 32'd1;
      end else if (pend_q) begin
        pc_d    = pend_tgt_q;
        pend_d  = 1'b0;
        count_d = count_q + 32'd1;
      end else begin
        pc_d    = pc_q + STEP_INC;
        count_d = count_q + 32'd1;
      end
    end
  end

  // State and output registers; reset is folded into the next-state logic.
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    cnt_q      <= cnt_d;
    pc_q       <= pc_d;
    ce_q       <= ce_d;
    misalign_q <= misalign_d;
    pend_q     <= pend_d;
    pend_tgt_q <= pend_tgt_d;
    count_q    <= count_d;
  end

  assign bus.pc                 = pc_q;
  assign bus.ce                 = ce_q;
  assign bus.pc_misalign_o      = misalign_q;
  assign bus.redirect_pending_o = pend_q;
  assign bus.fetch_count_o      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_pc_gen                                                    |
// | Brief    : Directed vector bench for pc_gen (32-bit and 8-bit builds).  |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst;
  logic rst8;

  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus  ();
  pc_gen_if #(.ADDR_W(8),  .STALL_W(6)) bus8 ();

  pc_gen #(
    .ADDR_W(32), .RESET_VECTOR(32'hBFC0_0000), .STEP(4),
    .STALL_W(6), .ENABLE_DELAY(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  pc_gen #(
    .ADDR_W(8), .RESET_VECTOR(8'hF0), .STEP(4),
    .STALL_W(6), .ENABLE_DELAY(1)
  ) dut8 (
    .clk(clk), .rst(rst8), .bus(bus8)
  );

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_mis;
    logic        exp_pend;
    logic [31:0] exp_cnt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] st, input logic fl, input logic [31:0] np,
                       input logic br, input logic [31:0] tg);
    bus.stall                   = st;
    bus.flush                   = fl;
    bus.new_pc                  = np;
    bus.branch_flag_i           = br;
    bus.branch_target_address_i = tg;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] p, input logic c,
                         input logic m, input logic pd, input logic [31:0] n);
    chk({tag, ".pc"},   bus.pc, p);
    chk({tag, ".ce"},   32'(bus.ce), 32'(c));
    chk({tag, ".mis"},  32'(bus.pc_misalign_o), 32'(m));
    chk({tag, ".pend"}, 32'(bus.redirect_pending_o), 32'(pd));
    chk({tag, ".cnt"},  bus.fetch_count_o, n);
  endtask

  initial begin
    //         stall  fl    new_pc        br    tgt           pc            mis   pend  cnt
    vecs[0]  = '{6'h00, 1'b1, 32'h100, 1'b0, 32'h0,   32'h100, 1'b0, 1'b0, 32'd2};
    vecs[1]  = '{6'h01, 1'b0, 32'h0,   1'b0, 32'h0,   32'h100, 1'b0, 1'b0, 32'd2};
    vecs[2]  = '{6'h01, 1'b0, 32'h0,   1'b1, 32'h200, 32'h100, 1'b0, 1'b1, 32'd2};
    vecs[3]  = '{6'h01, 1'b0, 32'h0,   1'b1, 32'h300, 32'h100, 1'b0, 1'b1, 32'd2};
    vecs[4]  = '{6'h00, 1'b0, 32'h0,   1'b0, 32'h0,   32'h300, 1'b0, 1'b0, 32'd3};
    vecs[5]  = '{6'h00, 1'b0, 32'h0,   1'b0, 32'h0,   32'h304, 1'b0, 1'b0, 32'd4};
    vecs[6]  = '{6'h01, 1'b0, 32'h0,   1'b1, 32'h300, 32'h304, 1'b0, 1'b1, 32'd4};
    vecs[7]  = '{6'h01, 1'b1, 32'h20,  1'b0, 32'h0,   32'h20,  1'b0, 1'b0, 32'd5};
    vecs[8]  = '{6'h01, 1'b0, 32'h0,   1'b1, 32'h300, 32'h20,  1'b0, 1'b1, 32'd5};
    vecs[9]  = '{6'h01, 1'b0, 32'h0,   1'b0, 32'h0,   32'h20,  1'b0, 1'b1, 32'd5};
    vecs[10] = '{6'h00, 1'b0, 32'h0,   1'b1, 32'h400, 32'h400, 1'b0, 1'b0, 32'd6};
    vecs[11] = '{6'h00, 1'b0, 32'h0,   1'b0, 32'h0,   32'h404, 1'b0, 1'b0, 32'd7};
    vecs[12] = '{6'h00, 1'b0, 32'h0,   1'b1, 32'h102, 32'h102, 1'b1, 1'b0, 32'd8};
    vecs[13] = '{6'h00, 1'b0, 32'h0,   1'b0, 32'h0,   32'h106, 1'b1, 1'b0, 32'd9};
    vecs[14] = '{6'h00, 1'b1, 32'h80,  1'b0, 32'h0,   32'h80,  1'b0, 1'b0, 32'd10};
    vecs[15] = '{6'h3E, 1'b0, 32'h0,   1'b0, 32'h0,   32'h84,  1'b0, 1'b0, 32'd11};
    vecs[16] = '{6'h01, 1'b0, 32'h0,   1'b0, 32'h0,   32'h84,  1'b0, 1'b0, 32'd11};

    rst  = 1'b0;
    rst8 = 1'b0;
    drive(6'h00, 1'b0, 32'h0, 1'b0, 32'h0);
    bus8.stall                   = '0;
    bus8.flush                   = 1'b0;
    bus8.new_pc                  = '0;
    bus8.branch_flag_i           = 1'b0;
    bus8.branch_target_address_i = '0;

    // Reset state.
    step();
    step();
    chk_all("reset", 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 32'd0);

    // Wake-up: three edges of ce=0 behaviour, flush/branch ignored meanwhile.
    rst = 1'b1;
    drive(6'h00, 1'b1, 32'h55, 1'b1, 32'h77);
    step();
    chk_all("wake1", 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    chk_all("wake2", 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    chk_all("wake3", 32'hBFC0_0000, 1'b1, 1'b0, 1'b0, 32'd0);
    drive(6'h00, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    chk_all("first_adv", 32'hBFC0_0004, 1'b1, 1'b0, 1'b0, 32'd1);

    // Table of RUN-state vectors.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].new_pc, vecs[i].br, vecs[i].tgt);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_pc, 1'b1, vecs[i].exp_mis,
              vecs[i].exp_pend, vecs[i].exp_cnt);
    end

    // Reset mid-operation discards a buffered redirect.
    drive(6'h01, 1'b0, 32'h0, 1'b1, 32'h500);
    step();
    chk_all("pend_before_rst", 32'h84, 1'b1, 1'b0, 1'b1, 32'd11);
    drive(6'h00, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    step();
    chk_all("mid_rst", 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    step();
    step();
    chk("rewake2.ce", 32'(bus.ce), 32'd0);
    step();
    chk_all("rewake3", 32'hBFC0_0000, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    chk_all("rewake_adv", 32'hBFC0_0004, 1'b1, 1'b0, 1'b0, 32'd1);

    // 8-bit build: ENABLE_DELAY=1 and silent wrap from 0xFC to 0x00.
    chk("w8.reset.ce", 32'(bus8.ce), 32'd0);
    chk("w8.reset.pc", 32'(bus8.pc), 32'hF0);
    rst8 = 1'b1;
    step();
    chk("w8.run.ce", 32'(bus8.ce), 32'd1);
    chk("w8.run.pc", 32'(bus8.pc), 32'hF0);
    step();
    step();
    step();
    chk("w8.top.pc", 32'(bus8.pc), 32'hFC);
    step();
    chk("w8.wrap.pc",  32'(bus8.pc), 32'h00);
    chk("w8.wrap.mis", 32'(bus8.pc_misalign_o), 32'd0);
    chk("w8.wrap.cnt", bus8.fetch_count_o, 32'd4);
    chk("w8.wrap.ce",  32'(bus8.ce), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
